// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and constants for the VRAM arbiter.
//   state_e  - arbiter FSM state (last handshake owner)
//   owner_e  - read-data owner tag carried alongside each RAM access
//   tag_t    - owner plus is-read flag for the return-data pipe
//   SLOT_PERIOD - pixels between display fetch slots
package vram_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_R0, TAG_R1} owner_e;
    typedef struct packed {
        owner_e owner;
        logic   rd;
    } tag_t;
    localparam int SLOT_PERIOD = 8;
endpackage

// File: rtl/vram_slot_timer.sv
// vram_slot_timer: flags the renderer's reserved fetch cycles.
//   hpos, vpos  - beam position from the sync generator
//   disp_slot   - high on one pixel per SLOT_PERIOD inside the visible area
module vram_slot_timer
    import vram_arb_pkg::*;
#(
    parameter int H_DISPLAY  = 256,
    parameter int V_DISPLAY  = 256,
    parameter int SLOT_PHASE = 0
) (
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    output logic       disp_slot
);
    localparam int PW = $clog2(SLOT_PERIOD);
    localparam logic [PW-1:0] PHASE = PW'(SLOT_PHASE);
    localparam logic [9:0] HD = 10'(H_DISPLAY);
    localparam logic [9:0] VD = 10'(V_DISPLAY);

    assign disp_slot = ({1'b0, hpos} < HD) && ({1'b0, vpos} < VD) && (hpos[PW-1:0] == PHASE);
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-port VRAM between the renderer (fixed slots) and
// two round-robin requesters.
//   clk, reset (async, active-low)
//   hpos, vpos, disp_addr         - renderer timing and fetch address
//   disp_slot, disp_rvalid        - slot flag and renderer read-data valid
//   reqN, weN, addrN, wdataN      - requester command, held until gntN
//   lockN                         - burst hold (only with VRAM_ARB_LOCK_EN)
//   gntN, rvalidN                 - grant and read-data valid per requester
//   ram_en/we/addr/wdata, ram_rdata - registered RAM command port, sync read data
// Optional feature macro: VRAM_ARB_LOCK_EN (locked bursts up to MAX_BURST).
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int H_DISPLAY  = 256,
    parameter int V_DISPLAY  = 256,
    parameter int SLOT_PHASE = 0,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_slot,
    output logic              disp_rvalid,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
`ifdef VRAM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    logic   slot_raw, slot, open, pref0, unused;
    state_e state, state_nx;
    tag_t   tag_nx, tag1, tag2;

    vram_slot_timer #(
        .H_DISPLAY (H_DISPLAY),
        .V_DISPLAY (V_DISPLAY),
        .SLOT_PHASE(SLOT_PHASE)
    ) u_slot (
        .hpos     (hpos),
        .vpos     (vpos),
        .disp_slot(slot_raw)
    );

    // Combinational outputs are forced low while reset is held.
    assign slot      = reset && slot_raw;
    assign open      = reset && !slot_raw;
    assign disp_slot = slot;

    // Read data goes straight to its consumer; the arbiter only qualifies it.
    assign unused = ^{ram_rdata, MAX_BURST[0]};

`ifdef VRAM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] burst, burst_nx;
    logic          hold0, hold1;

    // A locked owner keeps priority until it has used MAX_BURST grants.
    assign hold0 = (state == OWN0) && lock0 && (burst != '0) && (burst < CW'(MAX_BURST));
    assign hold1 = (state == OWN1) && lock1 && (burst != '0) && (burst < CW'(MAX_BURST));
    assign pref0 = hold0 || (!hold1 && state != OWN0);

    always_comb begin
        burst_nx = burst;
        if (gnt0)
            burst_nx = !lock0 ? '0 : (state == OWN0 && burst != '0) ?
                       ((burst == CW'(MAX_BURST)) ? burst : burst + 1'b1) : CW'(1);
        else if (gnt1)
            burst_nx = !lock1 ? '0 : (state == OWN1 && burst != '0) ?
                       ((burst == CW'(MAX_BURST)) ? burst : burst + 1'b1) : CW'(1);
        else if (open && !((state == OWN0) ? (req0 && lock0) : (state == OWN1) ? (req1 && lock1) : 1'b0))
            burst_nx = '0;
    end

    // Slot cycles leave the count untouched so a burst resumes after the slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            burst <= '0;
        else
            burst <= burst_nx;
    end
`else
    assign pref0 = (state != OWN0);
`endif

    always_comb begin
        gnt0     = open && req0 && (!req1 || pref0);
        gnt1     = open && req1 && (!req0 || !pref0);
        state_nx = gnt0 ? OWN0 : gnt1 ? OWN1 : state;
    end

    always_comb begin
        tag_nx = tag_t'{TAG_NONE, 1'b0};
        if (slot)
            tag_nx = tag_t'{TAG_DISP, 1'b1};
        else if (gnt0 && !we0)
            tag_nx = tag_t'{TAG_R0, 1'b1};
        else if (gnt1 && !we1)
            tag_nx = tag_t'{TAG_R1, 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            tag1      <= tag_t'{TAG_NONE, 1'b0};
            tag2      <= tag_t'{TAG_NONE, 1'b0};
        end else begin
            state     <= state_nx;
            ram_en    <= slot || gnt0 || gnt1;
            ram_we    <= gnt0 ? we0 : (gnt1 && we1);
            ram_addr  <= slot ? disp_addr : gnt0 ? addr0 : gnt1 ? addr1 : ram_addr;
            ram_wdata <= gnt0 ? wdata0 : gnt1 ? wdata1 : ram_wdata;
            tag1      <= tag_nx;
            tag2      <= tag1;
        end
    end

    assign disp_rvalid = tag2.rd && (tag2.owner == TAG_DISP);
    assign rvalid0     = tag2.rd && (tag2.owner == TAG_R0);
    assign rvalid1     = tag2.rd && (tag2.owner == TAG_R1);
endmodule
